// File: rtl/drate_decim_pkg.sv
// -----------------------------------------------------------------------------
// drate_decim_pkg
//   Shared definitions for the decimating FIR (drate_decim / drate_mac):
//   - lp coefficient macros (default coefficient width and tap count)
//   - clog2 helper and RATE / NMAC / accumulator-width derivations
//   - FSM state encoding
//   No ports (package).
// -----------------------------------------------------------------------------
`ifndef DRATE_DECIM_PKG_SV
`define DRATE_DECIM_PKG_SV

// Shared low-pass coefficient set geometry
`define LP_COEF_WIDTH 32
`define LP_COEF_TAPS  64

package drate_decim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Decimation ratio
    function automatic int calc_rate(input int f_h, input int f_l);
        return f_h / f_l;
    endfunction

    // MAC cycles per output: ceil(taps / lanes)
    function automatic int calc_nmac(input int taps, input int lanes);
        return (taps + lanes - 1) / lanes;
    endfunction

    // Full-precision accumulator width: product width plus growth for the tap sum
    function automatic int calc_accw(input int dw, input int cw, input int taps);
        return dw + cw + clog2(taps);
    endfunction

endpackage

`endif

// File: rtl/drate_mac.sv
// -----------------------------------------------------------------------------
// drate_mac
//   LANES signed multipliers feeding an adder tree, summed into a registered
//   full-precision accumulator.
//   Ports:
//     clk, rst_n : clock / async active-low reset
//     clr        : clear the accumulator (start of a new output)
//     en         : add this cycle's lane products to the accumulator
//     samples    : LANES signed samples, lane l at [l*DWIDTH +: DWIDTH]
//     coefs      : LANES signed coefficients, lane l at [l*CWIDTH +: CWIDTH]
//     acc        : accumulator (signed, AWIDTH bits)
// -----------------------------------------------------------------------------
module drate_mac
    import drate_decim_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 32,
    parameter int LANES  = 4,
    parameter int AWIDTH = 54
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       en,
    input  logic [LANES*DWIDTH-1:0]    samples,
    input  logic [LANES*CWIDTH-1:0]    coefs,
    output logic signed [AWIDTH-1:0]   acc
);

    localparam int PWIDTH = DWIDTH + CWIDTH;

    logic signed [PWIDTH-1:0] prod_s [LANES];
    logic signed [AWIDTH-1:0] sum_s;
    logic signed [AWIDTH-1:0] acc_r;

    // Lane products (full DWIDTH+CWIDTH precision) and their sign-extended sum
    always_comb begin
        sum_s = '0;
        for (int l = 0; l < LANES; l++) begin
            prod_s[l] = $signed(samples[l*DWIDTH +: DWIDTH]) * $signed(coefs[l*CWIDTH +: CWIDTH]);
            sum_s     = sum_s + AWIDTH'(prod_s[l]);
        end
    end

    // Accumulator: clear wins over accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= acc_r + sum_s;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/drate_decim.sv
// -----------------------------------------------------------------------------
// drate_decim
//   Decimating low-pass FIR: every RATE accepted input samples, the FIR_TAPS
//   most recent samples are snapshotted and filtered by a time-multiplexed
//   MAC engine (LANES taps per cycle, NMAC cycles), then reduced to DWIDTH.
//   Build option: define DRATE_SAT_EN to saturate the result to the DWIDTH
//   signed range; otherwise the result wraps (low DWIDTH bits kept).
//   Ports:
//     clk, rst_n : clock / async active-low reset
//     in_valid   : accept `in` on this edge
//     in         : signed input sample
//     coefs      : tap i at [i*CWIDTH +: CWIDTH]; held static while busy
//     out        : decimated signed sample, held between updates
//     out_valid  : one-cycle strobe when out updates
//     busy       : MAC engine active
//     overrun    : sticky, a decimation point arrived while the engine was busy
// -----------------------------------------------------------------------------
module drate_decim
    import drate_decim_pkg::*;
#(
    parameter int DWIDTH    = 16,
    parameter int CWIDTH    = `LP_COEF_WIDTH,
    parameter int F_H       = 60,
    parameter int F_L       = 3,
    parameter int FIR_TAPS  = `LP_COEF_TAPS,
    parameter int FIR_SLICE = 32,
    parameter int LANES     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [DWIDTH-1:0]           in,
    input  logic [FIR_TAPS*CWIDTH-1:0]  coefs,
    output logic [DWIDTH-1:0]           out,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int RATE   = calc_rate(F_H, F_L);
    localparam int NMAC   = calc_nmac(FIR_TAPS, LANES);
    localparam int AWIDTH = calc_accw(DWIDTH, CWIDTH, FIR_TAPS);
    localparam int PHW    = clog2(RATE);
    localparam int CNTW   = clog2(NMAC) + 1;
    // Past samples kept besides the current one; together they form the FIR window
    localparam int HIST   = FIR_TAPS - 1;

    localparam logic [PHW-1:0]  PH_LAST  = PHW'(RATE - 1);
    localparam logic [PHW-1:0]  PH_ONE   = PHW'(1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NMAC - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    logic [PHW-1:0]              phase_r;
    logic [DWIDTH-1:0]           hist_r [HIST];
    logic [DWIDTH-1:0]           snap_r [FIR_TAPS];
    state_t                      state_r;
    state_t                      state_s;
    logic [CNTW-1:0]             cnt_r;
    logic [CNTW-1:0]             cnt_s;
    logic                        mac_en_s;
    logic                        dec_s;
    logic                        accept_s;
    logic                        drop_s;
    logic [LANES*DWIDTH-1:0]     lane_smp_s;
    logic [LANES*CWIDTH-1:0]     lane_coef_s;
    logic signed [AWIDTH-1:0]    acc_s;
    logic signed [AWIDTH-1:0]    shifted_s;
    logic [DWIDTH-1:0]           res_s;
    logic [DWIDTH-1:0]           out_r;
    logic                        out_valid_r;
    logic                        busy_r;
    logic                        overrun_r;

`ifdef DRATE_SAT_EN
    localparam logic signed [AWIDTH-1:0] SAT_MAX = {{(AWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH-1:0] SAT_MIN = {{(AWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
`endif

    // A decimation point is the accepted sample that completes a group of RATE.
    // It can start a computation only when the engine is idle or finishing (OUT).
    assign dec_s    = in_valid && (phase_r == PH_LAST);
    assign accept_s = dec_s && ((state_r == ST_IDLE) || (state_r == ST_OUT));
    assign drop_s   = dec_s && (state_r == ST_MAC);

    // Phase counter over accepted samples, wraps after RATE-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= '0;
        end else if (in_valid) begin
            phase_r <= (phase_r == PH_LAST) ? '0 : (phase_r + PH_ONE);
        end
    end

    // Delay line of past samples (index 0 = most recent), shifts on every accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < HIST; j++) begin
                hist_r[j] <= '0;
            end
        end else if (in_valid) begin
            hist_r[0] <= in;
            for (int j = 1; j < HIST; j++) begin
                hist_r[j] <= hist_r[j-1];
            end
        end
    end

    // Snapshot of the window including the current sample (tap 0 = current)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < FIR_TAPS; j++) begin
                snap_r[j] <= '0;
            end
        end else if (accept_s) begin
            snap_r[0] <= in;
            for (int j = 0; j < HIST; j++) begin
                snap_r[j+1] <= hist_r[j];
            end
        end
    end

    // FSM next state: IDLE -> MAC (NMAC cycles) -> OUT -> IDLE, or OUT -> MAC back-to-back
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        mac_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_MAC;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                mac_en_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_OUT;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_OUT: begin
                if (accept_s) begin
                    state_s = ST_MAC;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // FSM state, MAC cycle counter and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Lane operand select: in MAC cycle m, lane l handles tap m*LANES+l.
    // Taps past FIR_TAPS never get a source, so those lanes multiply zero.
    always_comb begin
        lane_smp_s  = '0;
        lane_coef_s = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int m = 0; m * LANES + l < FIR_TAPS; m++) begin
                lane_smp_s[l*DWIDTH +: DWIDTH] = lane_smp_s[l*DWIDTH +: DWIDTH]
                    | ((cnt_r == CNTW'(m)) ? snap_r[m*LANES+l] : {DWIDTH{1'b0}});
                lane_coef_s[l*CWIDTH +: CWIDTH] = lane_coef_s[l*CWIDTH +: CWIDTH]
                    | ((cnt_r == CNTW'(m)) ? coefs[(m*LANES+l)*CWIDTH +: CWIDTH] : {CWIDTH{1'b0}});
            end
        end
    end

    drate_mac #(
        .DWIDTH (DWIDTH),
        .CWIDTH (CWIDTH),
        .LANES  (LANES),
        .AWIDTH (AWIDTH)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept_s),
        .en      (mac_en_s),
        .samples (lane_smp_s),
        .coefs   (lane_coef_s),
        .acc     (acc_s)
    );

    // Output scaling and reduction to DWIDTH
    always_comb begin
        shifted_s = acc_s >>> FIR_SLICE;
`ifdef DRATE_SAT_EN
        if (shifted_s > SAT_MAX) begin
            res_s = SAT_MAX[DWIDTH-1:0];
        end else if (shifted_s < SAT_MIN) begin
            res_s = SAT_MIN[DWIDTH-1:0];
        end else begin
            res_s = shifted_s[DWIDTH-1:0];
        end
`else
        res_s = DWIDTH'(shifted_s);
`endif
    end

    // Output register and strobe; the accumulator is final while in OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (state_r == ST_OUT) begin
            out_r       <= res_s;
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    // Sticky overrun: a decimation point arrived mid-computation and was dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_drate_decim.sv
// -----------------------------------------------------------------------------
// tb_drate_decim
//   Two instances share one stimulus stream: dut0 (LANES=4, NMAC=2) and
//   dut1 (LANES=1, NMAC=8, overruns under continuous input). A reference
//   model keeps the accepted-sample history, computes each decimated output
//   as a plain dot product and predicts strobe timing / overrun from the
//   engine occupancy window.
// -----------------------------------------------------------------------------
module tb_drate_decim;

    localparam int TAPS  = 8;
    localparam int CW    = 32;
    localparam int SLICE = 0;
    localparam int RATE  = 4;

`ifdef DRATE_SAT_EN
    localparam int SAT_EXP = 32767;
`else
    localparam int SAT_EXP = -8;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    iv;
    logic signed [15:0]      din;
    logic [TAPS*CW-1:0]      cf;
    logic signed [15:0]      out0;
    logic signed [15:0]      out1;
    logic                    ov0, ov1, busy0, busy1, orun0, orun1;

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     c [TAPS];
    int     hist [$];
    int     nacc;
    int     last_acc [2];
    bit     orun_m [2];
    longint last_out [2];
    longint ev [2][64];
    int     ed [2][64];
    int     hd [2];
    int     tl [2];
    longint got0 [$];

    always #5 clk = ~clk;

    drate_decim #(
        .DWIDTH(16), .CWIDTH(CW), .F_H(4), .F_L(1),
        .FIR_TAPS(TAPS), .FIR_SLICE(SLICE), .LANES(4)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in(din), .coefs(cf),
        .out(out0), .out_valid(ov0), .busy(busy0), .overrun(orun0)
    );

    drate_decim #(
        .DWIDTH(16), .CWIDTH(CW), .F_H(4), .F_L(1),
        .FIR_TAPS(TAPS), .FIR_SLICE(SLICE), .LANES(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in(din), .coefs(cf),
        .out(out1), .out_valid(ov1), .busy(busy1), .overrun(orun1)
    );

    function automatic int nmac(input int k);
        return (k == 0) ? 2 : 8;
    endfunction

    // Filter output for the current window: newest sample times c[0], etc.
    function automatic longint model_out();
        longint s;
        s = 0;
        for (int i = 0; i < hist.size() && i < TAPS; i++) begin
            s += longint'(hist[i]) * longint'(c[i]);
        end
        s = s >>> SLICE;
`ifdef DRATE_SAT_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s;
`else
        return longint'(shortint'(s));
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        nacc = 0;
        for (int k = 0; k < 2; k++) begin
            last_acc[k] = -100;
            orun_m[k]   = 1'b0;
            last_out[k] = 0;
            hd[k]       = 0;
            tl[k]       = 0;
        end
    endtask

    task automatic pack_coefs();
        for (int i = 0; i < TAPS; i++) cf[i*CW +: CW] = c[i];
    endtask

    task automatic check_dut(input int k, input logic signed [15:0] o, input logic v,
                             input logic b, input logic r);
        bit due;
        due = (tl[k] != hd[k]) && (ed[k][hd[k] % 64] == cyc);
        chk($sformatf("d%0d_out_valid@%0d", k, cyc), v, due);
        if (due) begin
            last_out[k] = ev[k][hd[k] % 64];
            hd[k]++;
        end
        if (k == 0 && v === 1'b1) got0.push_back(longint'(o));
        chk($sformatf("d%0d_out@%0d", k, cyc), o, last_out[k]);
        chk($sformatf("d%0d_busy@%0d", k, cyc), b,
            (cyc >= last_acc[k]) && (cyc < last_acc[k] + nmac(k) + 1));
        chk($sformatf("d%0d_overrun@%0d", k, cyc), r, orun_m[k]);
    endtask

    // One clock: drive, let the edge happen, update the model, then check both DUTs
    task automatic tick(input bit v, input int d);
        iv  = v;
        din = 16'(d);
        @(posedge clk);
        cyc++;
        if (v) begin
            hist.push_front(d);
            if (hist.size() > TAPS) void'(hist.pop_back());
            if (nacc % RATE == RATE - 1) begin
                for (int k = 0; k < 2; k++) begin
                    if (cyc >= last_acc[k] + nmac(k) + 1) begin
                        ev[k][tl[k] % 64] = model_out();
                        ed[k][tl[k] % 64] = cyc + nmac(k) + 1;
                        tl[k]++;
                        last_acc[k] = cyc;
                    end else begin
                        orun_m[k] = 1'b1;
                    end
                end
            end
            nacc++;
        end
        #1;
        check_dut(0, out0, ov0, busy0, orun0);
        check_dut(1, out1, ov1, busy1, orun1);
    endtask

    task automatic drain();
        repeat (12) tick(1'b0, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out0"}, out0, 0);
        chk({tag, "_ov0"}, ov0, 0);
        chk({tag, "_busy0"}, busy0, 0);
        chk({tag, "_orun0"}, orun0, 0);
        chk({tag, "_out1"}, out1, 0);
        chk({tag, "_ov1"}, ov1, 0);
        chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_orun1"}, orun1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        iv    = 1'b0;
        din   = '0;
        cf    = '0;
        for (int i = 0; i < TAPS; i++) c[i] = i + 1;
        pack_coefs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("por");
        rst_n = 1'b1;

        // Impulse, continuous input
        got0.delete();
        tick(1'b1, 1);
        repeat (15) tick(1'b1, 0);
        drain();
        chk("imp_count", got0.size(), 4);
        if (got0.size() >= 2) begin
            chk("imp_first", got0[0], 4);
            chk("imp_second", got0[1], 8);
        end
        chk("ovr_lanes1", orun1, 1);
        chk("ovr_lanes4", orun0, 0);

        // DC response
        for (int i = 0; i < TAPS; i++) c[i] = 1;
        pack_coefs();
        got0.delete();
        repeat (24) tick(1'b1, 100);
        drain();
        chk("dc_count", got0.size(), 6);
        if (got0.size() == 6) begin
            chk("dc_second", got0[1], 800);
            chk("dc_last", got0[5], 800);
        end

        // Full-scale DC: saturate or wrap depending on build
        got0.delete();
        repeat (16) tick(1'b1, 32767);
        drain();
        chk("sat_count", got0.size(), 4);
        if (got0.size() == 4) chk("sat_last", got0[3], SAT_EXP);

        // Reset in the middle of a computation
        for (int i = 0; i < TAPS; i++) c[i] = i + 1;
        pack_coefs();
        repeat (4) tick(1'b1, 5);
        tick(1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        model_reset();
        #1;
        rst_n = 1'b1;

        // Impulse with in_valid every other cycle
        got0.delete();
        tick(1'b1, 1);
        tick(1'b0, 0);
        repeat (15) begin
            tick(1'b1, 0);
            tick(1'b0, 0);
        end
        drain();
        chk("gap_count", got0.size(), 4);
        if (got0.size() >= 2) begin
            chk("gap_first", got0[0], 4);
            chk("gap_second", got0[1], 8);
        end

        // Random coefficients, samples and gaps
        for (int i = 0; i < TAPS; i++) c[i] = int'($urandom_range(0, 200)) - 100;
        pack_coefs();
        for (int n = 0; n < 120; n++) begin
            tick(($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535)) - 32768);
        end
        drain();
        chk("pending0", tl[0] - hd[0], 0);
        chk("pending1", tl[1] - hd[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
